// File: rtl/modinv_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : modinv_arbiter
// Description : Round-robin arbiter/sequencer sharing one modular_inversion
//               core among NREQ requesters. Optional a==0 rejection is built
//               when MODINV_ARB_ZCHK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module modinv_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_m,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_c,
    output logic              rsp_err,
    output logic              inv_start,
    output logic [W-1:0]      inv_b,
    output logic [W-1:0]      inv_a,
    output logic [W-1:0]      inv_m,
    input  logic [W-1:0]      inv_c,
    input  logic              inv_ready,
    input  logic              inv_busy,
    output logic              arb_busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [PW-1:0]  r_ptr;
    logic [PW-1:0]  r_gnt;
    logic [PW-1:0]  w_gidx;
    logic           w_found;
    logic           w_accept;
    logic           w_azero;
    logic           r_err;
    logic [W-1:0]   r_inv_b;
    logic [W-1:0]   r_inv_a;
    logic [W-1:0]   r_inv_m;
    logic [W-1:0]   r_rsp_c;
    logic           w_unused_busy;

    assign w_unused_busy = inv_busy;

    // Scan from the far end so the lowest offset from ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(r_ptr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_gidx  = PW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    assign w_accept = (r_state == ST_IDLE) && w_found && rst_n;

`ifdef MODINV_ARB_ZCHK_EN
    assign w_azero = (req_a[w_gidx*W +: W] == '0);
`else
    assign w_azero = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        rsp_valid   = '0;
        rsp_err     = 1'b0;
        inv_start   = 1'b0;
        arb_busy    = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    req_ready   = NREQ'(1) << w_gidx;
                    w_state_nxt = w_azero ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                inv_start   = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (inv_ready) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid   = NREQ'(1) << r_gnt;
                rsp_err     = r_err;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_err   <= 1'b0;
            r_inv_b <= '0;
            r_inv_a <= '0;
            r_inv_m <= '0;
            r_rsp_c <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_ptr   <= (w_gidx == PW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
                r_gnt   <= w_gidx;
                r_err   <= w_azero;
                r_inv_b <= req_b[w_gidx*W +: W];
                r_inv_a <= req_a[w_gidx*W +: W];
                r_inv_m <= req_m[w_gidx*W +: W];
            end
            // A rejected request leaves the previous result visible.
            if ((r_state == ST_WAIT) && inv_ready) begin
                r_rsp_c <= inv_c;
            end
        end
    end

    assign inv_b = r_inv_b;
    assign inv_a = r_inv_a;
    assign inv_m = r_inv_m;
    assign rsp_c = r_rsp_c;

endmodule
`default_nettype wire

// File: tb/tb_modinv_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_modinv_arbiter
// Description : Directed, table-driven bench for modinv_arbiter; the bench
//               plays the role of the inversion core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modinv_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 256;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_m;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_c;
    logic              rsp_err;
    logic              inv_start;
    logic [W-1:0]      inv_b;
    logic [W-1:0]      inv_a;
    logic [W-1:0]      inv_m;
    logic [W-1:0]      inv_c;
    logic              inv_ready;
    logic              inv_busy;
    logic              arb_busy;

    int                n_checks = 0;
    int                n_errors = 0;
    logic [W-1:0]      last_c;

    typedef struct {
        int         req;
        logic [W-1:0] b;
        logic [W-1:0] a;
        logic [W-1:0] m;
        logic [W-1:0] c;
    } vec_t;

    vec_t vt [5];

    modinv_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_b     (req_b),
        .req_a     (req_a),
        .req_m     (req_m),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_c     (rsp_c),
        .rsp_err   (rsp_err),
        .inv_start (inv_start),
        .inv_b     (inv_b),
        .inv_a     (inv_a),
        .inv_m     (inv_m),
        .inv_c     (inv_c),
        .inv_ready (inv_ready),
        .inv_busy  (inv_busy),
        .arb_busy  (arb_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int g, input logic [W-1:0] b, input logic [W-1:0] a,
                           input logic [W-1:0] m);
        req_b[g*W +: W] = b;
        req_a[g*W +: W] = a;
        req_m[g*W +: W] = m;
        req_valid[g]    = 1'b1;
    endtask

    // One full service: accept, start, two wait cycles, core completion, response.
    task automatic serve(input int g, input logic [W-1:0] b, input logic [W-1:0] a,
                         input logic [W-1:0] m, input logic [W-1:0] c,
                         input bit keep, input logic [NREQ-1:0] raise);
        int n;
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << g;
        n  = 0;
        #1;
        while (req_ready == '0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("grant", W'(req_ready), W'(oh));
        @(posedge clk); #1;
        if (!keep) req_valid[g] = 1'b0;
        check("inv_start_issue", W'(inv_start), W'(1'b1));
        check("ready_busy", W'(req_ready), '0);
        check("inv_b", inv_b, b);
        check("inv_a", inv_a, a);
        check("inv_m", inv_m, m);
        @(posedge clk); #1;
        check("inv_start_wait", W'(inv_start), '0);
        req_valid = req_valid | raise;
        @(posedge clk); #1;
        inv_c     = c;
        inv_ready = 1'b1;
        @(posedge clk); #1;
        inv_ready = 1'b0;
        inv_c     = '0;
        check("rsp_valid", W'(rsp_valid), W'(oh));
        check("rsp_c", rsp_c, c);
        check("rsp_err", W'(rsp_err), '0);
        last_c = c;
        @(posedge clk); #1;
        check("rsp_valid_clr", W'(rsp_valid), '0);
        check("rsp_c_hold", rsp_c, c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{2, W'(1), W'(3),  W'(7),      W'(5)};
        vt[1] = '{0, W'(5), W'(4),  W'(13),     W'(11)};
        vt[2] = '{1, W'(1), W'(2),  W'(11),     W'(6)};
        vt[3] = '{0, W'(2), W'(2),  {W{1'b1}},  W'(1)};
        vt[4] = '{3, W'(3), W'(3),  W'(7),      W'(1)};

        rst_n     = 1'b0;
        req_valid = '0;
        req_b     = '0;
        req_a     = '0;
        req_m     = '0;
        inv_c     = '0;
        inv_ready = 1'b0;
        inv_busy  = 1'b0;
        last_c    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", W'(req_ready), '0);
        check("rst_rsp_valid", W'(rsp_valid), '0);
        check("rst_rsp_c", rsp_c, '0);
        check("rst_inv_start", W'(inv_start), '0);
        check("rst_inv_a", inv_a, '0);
        check("rst_arb_busy", W'(arb_busy), '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-requester transactions from the table.
        for (int i = 0; i < 5; i++) begin
            set_req(vt[i].req, vt[i].b, vt[i].a, vt[i].m);
            serve(vt[i].req, vt[i].b, vt[i].a, vt[i].m, vt[i].c, 1'b0, '0);
        end

        // All four valid together: rotation 0,1,2,3 with b=i+1, a=2, m=11.
        for (int i = 0; i < NREQ; i++) set_req(i, W'(i + 1), W'(2), W'(11));
        serve(0, W'(1), W'(2), W'(11), W'(6), 1'b0, '0);
        serve(1, W'(2), W'(2), W'(11), W'(1), 1'b0, '0);
        serve(2, W'(3), W'(2), W'(11), W'(7), 1'b0, '0);
        serve(3, W'(4), W'(2), W'(11), W'(2), 1'b0, '0);

        // Requester 3 held valid; requester 1 arrives mid-service and goes next.
        set_req(3, W'(1), W'(3), W'(7));
        req_b[1*W +: W] = W'(1);
        req_a[1*W +: W] = W'(2);
        req_m[1*W +: W] = W'(11);
        serve(3, W'(1), W'(3), W'(7), W'(5), 1'b1, 4'b0010);
        serve(1, W'(1), W'(2), W'(11), W'(6), 1'b0, '0);
        serve(3, W'(1), W'(3), W'(7), W'(5), 1'b0, '0);

`ifdef MODINV_ARB_ZCHK_EN
        // a==0 is rejected without touching the core.
        set_req(0, W'(5), W'(0), W'(7));
        #1;
        check("z_grant", W'(req_ready), W'(4'b0001));
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        check("z_inv_start", W'(inv_start), '0);
        check("z_rsp_valid", W'(rsp_valid), W'(4'b0001));
        check("z_rsp_err", W'(rsp_err), W'(1'b1));
        check("z_rsp_c", rsp_c, last_c);
        set_req(1, W'(1), W'(3), W'(7));
        serve(1, W'(1), W'(3), W'(7), W'(5), 1'b0, '0);
`endif

        // Stray completion pulse while idle must be ignored.
        inv_c     = W'(32'hdead);
        inv_ready = 1'b1;
        @(posedge clk); #1;
        inv_ready = 1'b0;
        inv_c     = '0;
        check("idle_busy", W'(arb_busy), '0);
        check("idle_rsp_valid", W'(rsp_valid), '0);
        check("idle_rsp_c", rsp_c, last_c);
        @(posedge clk); #1;
        check("idle_rsp_valid2", W'(rsp_valid), '0);

        // Reset while waiting on the core: outputs clear, pointer restarts at 0.
        set_req(1, W'(9), W'(5), W'(13));
        #1;
        check("rw_grant", W'(req_ready), W'(4'b0010));
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        set_req(0, W'(1), W'(3), W'(7));
        set_req(2, W'(1), W'(2), W'(11));
        rst_n     = 1'b0;
        inv_c     = W'(32'hbeef);
        inv_ready = 1'b1;
        #1;
        check("rw_req_ready", W'(req_ready), '0);
        check("rw_rsp_valid", W'(rsp_valid), '0);
        check("rw_rsp_c", rsp_c, '0);
        check("rw_inv_start", W'(inv_start), '0);
        check("rw_inv_a", inv_a, '0);
        check("rw_arb_busy", W'(arb_busy), '0);
        @(posedge clk); #1;
        inv_ready = 1'b0;
        inv_c     = '0;
        rst_n     = 1'b1;
        check("rw_no_rsp", W'(rsp_valid), '0);
        serve(0, W'(1), W'(3), W'(7), W'(5), 1'b0, '0);
        serve(2, W'(1), W'(2), W'(11), W'(6), 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/modinv_arbiter.md
# modinv_arbiter

Round-robin arbiter and sequencer that shares one `modular_inversion` core (c = b·a⁻¹ mod m, 256-bit) among several point-arithmetic requesters in the ECC datapath. It accepts one request at a time over a valid/ready handshake and registers its operands. It then issues a single-cycle start to the core, waits for the core's completion pulse, and returns the result to the granted requester with a one-cycle response strobe.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `W`, 256, operand width; must match core
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  NREQ  request pending per requester; held until accepted
- `req_b`, `req_a`, `req_m`  in  NREQ*W  packed operands, slice i = [i*W +: W]
- `req_ready`  out  NREQ  one-hot accept strobe; a request is accepted when `req_valid[i] & req_ready[i]`
- `rsp_valid`  out  NREQ  one-hot, one-cycle response strobe
- `rsp_c`  out  W  result; valid while `rsp_valid` is nonzero, held until next response
- `rsp_err`  out  1  qualifies `rsp_valid`: a==0 rejected (only with `MODINV_ARB_ZCHK_EN`)
- `inv_start`  out  1  core start pulse
- `inv_b`, `inv_a`, `inv_m`  out  W  registered operands to core
- `inv_c`  in  W  core result
- `inv_ready`  in  1  core one-cycle completion pulse
- `inv_busy`  in  1  core busy (status only; not used for sequencing)
- `arb_busy`  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `req_valid`, grant the first set bit at or after `ptr` (wrapping modulo NREQ). Assert `req_ready[g]` combinationally, latch operands and g into `gnt`, then go to ISSUE. With no request, stay in IDLE.
- Pointer update: on accept, `ptr <= (g+1) mod NREQ`; otherwise `ptr` holds.
- ISSUE: `inv_start=1` for exactly one cycle; go to WAIT.
- WAIT: on `inv_ready`, capture `inv_c` into `rsp_c` and go to RESP. No timeout.
- RESP: `rsp_valid[gnt]=1`, `rsp_err=0`; go to IDLE.
- `req_ready` is zero outside IDLE. A requester may drop `req_valid` before it is accepted, with no side effect.
- `inv_b`/`inv_a`/`inv_m` are stable from ISSUE until the next accept.
- A new `req_valid` arriving during ISSUE, WAIT or RESP waits for IDLE. No request is lost or reordered within a requester.
- `inv_ready` outside WAIT is ignored.

## Timing
- Reset values: `req_ready=0`, `rsp_valid=0`, `rsp_err=0`, `rsp_c=0`, `inv_start=0`, `inv_*` operands 0, `arb_busy=0`, `ptr=0`, state IDLE.
- Reset mid-operation: everything returns to reset values immediately. Any in-flight result is discarded and no `rsp_valid` is produced.
- Cycle timeline:
  - Accept at cycle T.
  - `inv_start` at T+1.
  - `inv_ready` sampled at cycle R ≥ T+2.
  - `rsp_valid` at R+1.
  - Earliest next accept at R+2.
- With the zero check active, rejection timing is: accept at T, `rsp_valid` and `rsp_err` at T+1, next accept at T+2.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0. A requester waits at most NREQ-1 services.

## Configuration
- `MODINV_ARB_ZCHK_EN` defined: at accept, an operand a==0 is flagged. The core never terminates for a==0, so such a request is not issued. The FSM goes directly to RESP with `rsp_err=1` and `rsp_c` unchanged.
- `MODINV_ARB_ZCHK_EN` undefined: no check; `rsp_err` is tied to 0. The a==0 case is excluded by the requesters.

## Test plan
- Single request, requester 2: b=1, a=3, m=7. Expect `inv_start` one cycle after accept and `rsp_valid=4'b0100` one cycle after `inv_ready`, with `rsp_c=5`.
- All four requesters valid from the same cycle, each with a=2, m=11 and b=i+1. Expect grant order 0,1,2,3 and responses `rsp_c`=6,1,7,2.
- Requester 3 continuously valid while requester 1 raises valid mid-service. Expect requester 1 granted next, before requester 3's second grant.
- Assert rst_n during WAIT. Expect all outputs 0 that cycle, no `rsp_valid`, and the next request granted from `ptr=0`.
- With `MODINV_ARB_ZCHK_EN`: a=0 on requester 0. Expect no `inv_start`, `rsp_valid=4'b0001` and `rsp_err=1` at T+1. A following valid request on requester 1 is serviced normally.
- `inv_ready` pulse injected while in IDLE. Expect no state change and no `rsp_valid`.
